// File: rtl/id_token_scanner_pkg.sv
// Shared constants and encodings for the identifier token scanner.
// ASCII class bounds, the 2-bit character class and the scanner state encoding.
package id_scan_pkg;

  localparam logic [7:0] A_UP_LO    = 8'd65;
  localparam logic [7:0] A_UP_HI    = 8'd90;
  localparam logic [7:0] A_LO_LO    = 8'd97;
  localparam logic [7:0] A_LO_HI    = 8'd122;
  localparam logic [7:0] DIG_LO     = 8'd48;
  localparam logic [7:0] DIG_HI     = 8'd57;
  localparam logic [7:0] UNDERSCORE = 8'd95;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_ALPHA = 2'd1,
    CLS_DIGIT = 2'd2
  } cls_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALPHA = 2'd1,
    S_DIGIT = 2'd2,
    S_NUM   = 2'd3
  } state_t;

endpackage

// File: rtl/id_token_scanner_if.sv
// Character input and token output handshakes of the identifier scanner.
// master = character source / token consumer side, slave = scanner side.
interface id_token_scanner_if #(
  parameter int LEN_W = 5
);
  logic             in_valid;
  logic [7:0]       in_char;
  logic             in_last;
  logic             in_ready;
  logic             tok_valid;
  logic             tok_ready;
  logic [LEN_W-1:0] tok_len;
  logic             tok_has_digit;
  logic             tok_overflow;

  modport master (
    output in_valid, in_char, in_last, tok_ready,
    input  in_ready, tok_valid, tok_len, tok_has_digit, tok_overflow
  );

  modport slave (
    input  in_valid, in_char, in_last, tok_ready,
    output in_ready, tok_valid, tok_len, tok_has_digit, tok_overflow
  );
endinterface

// File: rtl/id_token_scanner_char_class.sv
// Combinational ASCII classifier: ALPHA (letters, optionally '_'), DIGIT, or OTHER.
module id_char_class
  import id_scan_pkg::*;
#(
  parameter int UNDERSCORE_EN = 1
) (
  input  logic [7:0] ch,
  output cls_t       cls
);

  always_comb begin
    cls = CLS_OTHER;
    if ((ch >= A_UP_LO && ch <= A_UP_HI) ||
        (ch >= A_LO_LO && ch <= A_LO_HI) ||
        ((UNDERSCORE_EN != 0) && ch == UNDERSCORE)) begin
      cls = CLS_ALPHA;
    end else if (ch >= DIG_LO && ch <= DIG_HI) begin
      cls = CLS_DIGIT;
    end
  end

endmodule

// File: rtl/id_token_scanner.sv
// Streaming identifier tokenizer: one record per ALPHA (ALPHA|DIGIT)* run.
//  state   | meaning
//  S_IDLE  | between words, no identifier open
//  S_ALPHA | identifier open, last char a letter
//  S_DIGIT | identifier open, last char a digit
//  S_NUM   | inside a numeric literal, swallowed until OTHER
module id_token_scanner
  import id_scan_pkg::*;
#(
  parameter  int MAX_LEN       = 16,
  parameter  int UNDERSCORE_EN = 1,
  parameter  int CNT_W         = 16,
  localparam int LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  id_token_scanner_if.slave  bus,
  output logic               suffix_match,
  output logic [CNT_W-1:0]   id_count
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             hd_q, hd_d;
  logic             ovf_q, ovf_d;
  logic             fire;
  logic             emit;
  cls_t             cls;

  id_char_class #(.UNDERSCORE_EN(UNDERSCORE_EN)) u_class (
    .ch  (bus.in_char),
    .cls (cls)
  );

  // Stalled token blocks input so no record is ever overwritten.
  assign bus.in_ready = ~bus.tok_valid | bus.tok_ready;
  assign fire         = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hd_d    = hd_q;
    ovf_d   = ovf_q;
    emit    = 1'b0;
    if (fire) begin
      unique case (state_q)
        S_IDLE: begin
          if (cls == CLS_ALPHA) begin
            state_d = S_ALPHA;
            len_d   = LEN_W'(1);
            hd_d    = 1'b0;
            ovf_d   = 1'b0;
          end else if (cls == CLS_DIGIT) begin
            state_d = S_NUM;
          end
        end
        S_ALPHA, S_DIGIT: begin
          if (cls == CLS_OTHER) begin
            emit    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = (cls == CLS_DIGIT) ? S_DIGIT : S_ALPHA;
            if (cls == CLS_DIGIT) hd_d = 1'b1;
            if (len_q == LEN_W'(MAX_LEN)) ovf_d = 1'b1;
            else                          len_d = len_q + LEN_W'(1);
          end
        end
        S_NUM: begin
          if (cls == CLS_OTHER) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      // Last char is consumed first, then any still-open identifier closes.
      if (bus.in_last) begin
        if (state_d == S_ALPHA || state_d == S_DIGIT) emit = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      hd_q         <= 1'b0;
      ovf_q        <= 1'b0;
      suffix_match <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hd_q    <= hd_d;
      ovf_q   <= ovf_d;
      if (fire) suffix_match <= (state_d == S_DIGIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tok_valid     <= 1'b0;
      bus.tok_len       <= '0;
      bus.tok_has_digit <= 1'b0;
      bus.tok_overflow  <= 1'b0;
      id_count          <= '0;
    end else if (emit) begin
      bus.tok_valid     <= 1'b1;
      bus.tok_len       <= len_d;
      bus.tok_has_digit <= hd_d;
      bus.tok_overflow  <= ovf_d;
      id_count          <= id_count + CNT_W'(1);
    end else if (bus.tok_ready) begin
      bus.tok_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_token_scanner.sv
// Bench for id_token_scanner: three configurations driven in parallel, each
// checked against a word-level tokenizer model (runs of alnum chars).
module tb_id_token_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'd0;
  logic       in_last = 1'b0;
  logic       tok_ready = 1'b0;

  id_token_scanner_if #(.LEN_W(5)) if0 ();
  id_token_scanner_if #(.LEN_W(3)) if1 ();
  id_token_scanner_if #(.LEN_W(5)) if2 ();

  logic        suf0, suf1, suf2;
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  id_token_scanner #(.MAX_LEN(16), .UNDERSCORE_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .suffix_match(suf0), .id_count(cnt0));
  id_token_scanner #(.MAX_LEN(4), .UNDERSCORE_EN(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .suffix_match(suf1), .id_count(cnt1));
  id_token_scanner #(.MAX_LEN(16), .UNDERSCORE_EN(0), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .suffix_match(suf2), .id_count(cnt2));

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.in_char  = in_char;   assign if1.in_char  = in_char;   assign if2.in_char  = in_char;
  assign if0.in_last  = in_last;   assign if1.in_last  = in_last;   assign if2.in_last  = in_last;
  assign if0.tok_ready = tok_ready; assign if1.tok_ready = tok_ready; assign if2.tok_ready = tok_ready;

  logic [2:0]  o_rdy, o_tv, o_hd, o_ovf, o_suf;
  logic [4:0]  o_len [3];
  logic [15:0] o_cnt [3];
  assign o_rdy = {if2.in_ready, if1.in_ready, if0.in_ready};
  assign o_tv  = {if2.tok_valid, if1.tok_valid, if0.tok_valid};
  assign o_hd  = {if2.tok_has_digit, if1.tok_has_digit, if0.tok_has_digit};
  assign o_ovf = {if2.tok_overflow, if1.tok_overflow, if0.tok_overflow};
  assign o_suf = {suf2, suf1, suf0};
  assign o_len[0] = if0.tok_len;
  assign o_len[1] = {2'b00, if1.tok_len};
  assign o_len[2] = if2.tok_len;
  assign o_cnt[0] = cnt0;
  assign o_cnt[1] = cnt1;
  assign o_cnt[2] = {13'd0, cnt2};

  // Per-configuration model state.
  int maxl  [3] = '{16, 4, 16};
  bit usen  [3] = '{1'b1, 1'b1, 1'b0};
  int cmask [3] = '{65535, 65535, 7};
  int wlen [3];
  bit wfa  [3];
  bit wdig [3];
  bit pend [3];
  int rlen [3];
  bit rhd  [3];
  bit rovf [3];
  int mcnt [3];
  bit msuf [3];

  int compared = 0;
  int mismatched = 0;

  function automatic int klass(input logic [7:0] c, input bit us);
    if ((c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122) || (us && c == 8'd95)) return 1;
    if (c >= 8'd48 && c <= 8'd57) return 2;
    return 0;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s dut%0d: observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      wlen[k] = 0; wfa[k] = 0; wdig[k] = 0; pend[k] = 0;
      rlen[k] = 0; rhd[k] = 0; rovf[k] = 0; mcnt[k] = 0; msuf[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("in_ready", k, 32'(o_rdy[k]), 32'(!pend[k] || tok_ready));
      chk("tok_valid", k, 32'(o_tv[k]), 32'(pend[k]));
      if (pend[k]) begin
        chk("tok_len", k, 32'(o_len[k]), 32'(rlen[k]));
        chk("tok_has_digit", k, 32'(o_hd[k]), 32'(rhd[k]));
        chk("tok_overflow", k, 32'(o_ovf[k]), 32'(rovf[k]));
      end
      chk("suffix_match", k, 32'(o_suf[k]), 32'(msuf[k]));
      chk("id_count", k, 32'(o_cnt[k]), 32'(mcnt[k]));
    end
  endtask

  // Word-level view: a token is an alnum run whose first char is a letter.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit f;
      bit ended;
      int c;
      f = in_valid && (!pend[k] || tok_ready);
      if (pend[k] && tok_ready) pend[k] = 0;
      if (f) begin
        c = klass(in_char, usen[k]);
        ended = (c == 0) || in_last;
        if (c != 0) begin
          wlen[k]++;
          if (wlen[k] == 1) wfa[k] = (c == 1);
          if (c == 2) wdig[k] = 1;
        end
        msuf[k] = !ended && wfa[k] && (c == 2);
        if (ended && wlen[k] > 0 && wfa[k]) begin
          pend[k] = 1;
          rlen[k] = (wlen[k] > maxl[k]) ? maxl[k] : wlen[k];
          rovf[k] = wlen[k] > maxl[k];
          rhd[k]  = wdig[k];
          mcnt[k] = (mcnt[k] + 1) & cmask[k];
        end
        if (ended) begin
          wlen[k] = 0; wdig[k] = 0; wfa[k] = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] c, input bit l, input bit r, output bit acc0);
    in_valid = v; in_char = c; in_last = l; tok_ready = r;
    @(negedge clk);
    check_all();
    acc0 = v && (!pend[0] || r);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    bit a;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, r, a);
  endtask

  task automatic send_str(input string s, input bit last_at_end, input bit r);
    for (int i = 0; i < s.len(); i++) begin
      bit acc;
      int tries;
      tries = 0;
      acc = 0;
      while (!acc && tries < 8) begin
        cyc(1'b1, s[i], last_at_end && (i == s.len() - 1), r, acc);
        tries++;
      end
      if (!acc) begin
        compared++;
        mismatched++;
        $error("FAIL send_timeout: char %0d of '%s' observed not accepted expected accepted", i, s);
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 0; in_last = 0;
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_tok_valid", k, 32'(o_tv[k]), 32'd0);
      chk("rst_tok_len", k, 32'(o_len[k]), 32'd0);
      chk("rst_has_digit", k, 32'(o_hd[k]), 32'd0);
      chk("rst_overflow", k, 32'(o_ovf[k]), 32'd0);
      chk("rst_suffix", k, 32'(o_suf[k]), 32'd0);
      chk("rst_id_count", k, 32'(o_cnt[k]), 32'd0);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    string alph;
    bit a;
    alph = "aZq_09 ;x5B";
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle(1, 1'b1);

    send_str("ab12 ", 1'b0, 1'b1);     idle(2, 1'b1);
    send_str("9x7 a ", 1'b0, 1'b1);    idle(2, 1'b1);
    send_str("abcdefg;", 1'b0, 1'b1);  idle(2, 1'b1);

    send_str("a ", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd98, 1'b0, 1'b0, a);
    send_str("b c ", 1'b0, 1'b1);      idle(2, 1'b1);

    send_str("x_1", 1'b1, 1'b1);       idle(2, 1'b1);

    send_str("abc", 1'b0, 1'b1);
    do_reset();
    send_str("d ", 1'b0, 1'b1);        idle(2, 1'b1);
    send_str("w ", 1'b0, 1'b0);        idle(1, 1'b0);
    do_reset();
    idle(1, 1'b1);

    for (int i = 0; i < 900; i++) begin
      int idx;
      idx = int'($urandom_range(0, alph.len() - 1));
      cyc($urandom_range(0, 3) != 0, alph[idx], $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0, a);
    end
    idle(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
